// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - mode and SR-policy encodings plus the shared one-bit next-state function
package ff_bank_pkg;

  localparam int MODE_W = 2;
  localparam int POL_W  = 2;

  localparam logic [MODE_W-1:0] MODE_SR = 2'd0;
  localparam logic [MODE_W-1:0] MODE_JK = 2'd1;
  localparam logic [MODE_W-1:0] MODE_D  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_T  = 2'd3;

  localparam logic [POL_W-1:0] POL_HOLD = 2'd0;
  localparam logic [POL_W-1:0] POL_SET  = 2'd1;
  localparam logic [POL_W-1:0] POL_RST  = 2'd2;
  localparam logic [POL_W-1:0] POL_TOG  = 2'd3;

  // Next value of one enabled flip-flop bit. In D and T modes r is ignored.
  function automatic logic ff_next(
    input logic [MODE_W-1:0] mode,
    input logic [POL_W-1:0]  policy,
    input logic              q,
    input logic              s,
    input logic              r
  );
    logic nxt;
    nxt = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11: begin
            case (policy)
              POL_SET: nxt = 1'b1;
              POL_RST: nxt = 1'b0;
              POL_TOG: nxt = ~q;
              default: nxt = q;
            endcase
          end
          default: nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_D:  nxt = s;
      default: nxt = s ? ~q : q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - one universal flip-flop channel: next-state logic and its register
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              s,
  input  logic              r,
  input  logic              rst_val,
  input  logic [POL_W-1:0]  policy,
  output logic              q
);

  logic q_q;
  logic q_d;

  // Compute the next bit value; a disabled cell holds.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = ff_next(mode, policy, q_q, s, r);
    end
  end

  // State register with synchronous reset to the channel's reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - WIDTH-channel SR/JK/D/T flip-flop bank with illegal-input flag and saturating error counter
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter logic [POL_W-1:0]   SR_POLICY = POL_HOLD,
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  s,
  input  logic [WIDTH-1:0]  r,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_w;
  logic             illegal;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .s       (s[i]),
      .r       (r[i]),
      .rst_val (RESET_VAL[i]),
      .policy  (SR_POLICY),
      .q       (q_w[i])
    );
  end

  // One offending cycle counts once, however many channels have s=r=1.
  assign illegal = en & (mode == MODE_SR) & (|(s & r));

  // Error flag and counter next state; clear wins and still counts this cycle.
  always_comb begin
    err_d = illegal;
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = illegal ? CNT_W'(1) : '0;
    end else if (illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error state registers; reset overrides err_clr and en.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_w;
  assign qn      = ~q_w;
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// tb/tb_ff_bank.sv - directed self-checking bench for ff_bank across all SR policies and a non-zero reset value
module tb_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] s;
  logic [3:0] r;
  logic       err_clr;

  logic [3:0] q0, q1, q2, q3, q6;
  logic [3:0] qn0, qn1, qn2, qn3, qn6;
  logic       err0, err1, err2, err3, err6;
  logic [2:0] cnt0, cnt1, cnt2, cnt3, cnt6;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_POLICY(2'd0), .CNT_W(3)) u_pol0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q0), .qn(qn0), .err(err0), .err_cnt(cnt0));
  ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_POLICY(2'd1), .CNT_W(3)) u_pol1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q1), .qn(qn1), .err(err1), .err_cnt(cnt1));
  ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_POLICY(2'd2), .CNT_W(3)) u_pol2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q2), .qn(qn2), .err(err2), .err_cnt(cnt2));
  ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .SR_POLICY(2'd3), .CNT_W(3)) u_pol3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q3), .qn(qn3), .err(err3), .err_cnt(cnt3));
  ff_bank #(.WIDTH(4), .RESET_VAL(4'h6), .SR_POLICY(2'd0), .CNT_W(3)) u_rv6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
    .q(q6), .qn(qn6), .err(err6), .err_cnt(cnt6));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst_v, input logic en_v, input logic [1:0] mode_v,
                       input logic [3:0] s_v, input logic [3:0] r_v, input logic clr_v);
    rst     = rst_v;
    en      = en_v;
    mode    = mode_v;
    s       = s_v;
    r       = r_v;
    err_clr = clr_v;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    step();
    check("rst_q", q0, 4'h0);
    check("rst_qn", qn0, 4'hF);
    check("rst_err", err0, 1'b0);
    check("rst_cnt", cnt0, 3'd0);
    check("rst_q_rv6", q6, 4'h6);

    // Hold with en=0 even with s asserted.
    drive(1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("hold_q", q0, 4'h0);
      check("hold_qn", qn0, 4'hF);
      check("hold_err", err0, 1'b0);
      check("hold_cnt", cnt0, 3'd0);
    end

    // SR basic
    drive(1'b0, 1'b1, 2'd0, 4'b0101, 4'b0000, 1'b0);
    step();
    check("sr_set", q0, 4'b0101);
    check("sr_qn", qn0, 4'b1010);
    drive(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b0);
    step();
    check("sr_clr", q0, 4'b0100);
    drive(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step();
    check("sr_hold", q0, 4'b0100);
    check("sr_hold_p3", q3, 4'b0100);

    // Illegal input under each policy
    drive(1'b0, 1'b1, 2'd0, 4'b1100, 4'b1100, 1'b0);
    step();
    check("pol_hold_q", q0, 4'b0100);
    check("pol_set_q", q1, 4'b1100);
    check("pol_rst_q", q2, 4'b0000);
    check("pol_tog_q", q3, 4'b1000);
    check("ill_err0", err0, 1'b1);
    check("ill_err1", err1, 1'b1);
    check("ill_err2", err2, 1'b1);
    check("ill_err3", err3, 1'b1);
    check("ill_cnt0", cnt0, 3'd1);
    check("ill_cnt3", cnt3, 3'd1);
    drive(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b0);
    step();
    check("ill_err_drop", err0, 1'b0);
    check("ill_cnt_hold", cnt0, 3'd1);
    check("ill_q_after_p3", q3, 4'b1000);

    // Saturation: count starts at 1, climbs to 7 and sticks.
    drive(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("sat_cnt", cnt0, (k + 1 > 7) ? 3'd7 : 3'(k + 1));
      check("sat_err", err0, 1'b1);
    end
    drive(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 1'b1);
    step();
    check("clr_ill_cnt", cnt0, 3'd1);
    drive(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1);
    step();
    check("clr_cnt", cnt0, 3'd0);
    check("clr_err", err0, 1'b0);

    // en=0 masks the illegal condition; err_clr still acts without en.
    drive(1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0);
    step();
    check("dis_err", err0, 1'b0);
    check("dis_cnt_hold", cnt0, 3'd1);
    drive(1'b0, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1);
    step();
    check("dis_clr_cnt", cnt0, 3'd0);

    // JK, D, T from zero
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'd1, 4'hF, 4'hF, 1'b0);
    step();
    check("jk_tog1", q0, 4'hF);
    check("jk_err", err0, 1'b0);
    step();
    check("jk_tog2", q0, 4'h0);
    check("jk_cnt", cnt0, 3'd0);
    drive(1'b0, 1'b1, 2'd2, 4'hA, 4'h5, 1'b0);
    step();
    check("d_load", q0, 4'hA);
    drive(1'b0, 1'b1, 2'd3, 4'h3, 4'hF, 1'b0);
    step();
    check("t_tog", q0, 4'b1001);
    check("t_err", err0, 1'b0);

    // Reset mid-operation with err_cnt=5 and err_clr high
    drive(1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("pre_rst_cnt", cnt0, 3'd5);
    drive(1'b0, 1'b1, 2'd3, 4'hF, 4'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 2'd3, 4'hF, 4'h0, 1'b1);
    step();
    check("mid_rst_q", q0, 4'h0);
    check("mid_rst_q_rv6", q6, 4'h6);
    check("mid_rst_qn_rv6", qn6, 4'h9);
    check("mid_rst_err", err0, 1'b0);
    check("mid_rst_cnt", cnt0, 3'd0);
    check("mid_rst_cnt_rv6", cnt6, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
